// File: rtl/pea_pkg.sv
// Shared definitions for the PEA polynomial-evaluation (EVP) stage.
// Provides the default datapath sizes, the FSM state encoding and a helper
// that packs the status word {16'h0, n[7:0], 6'b0, bad_deg, ovf}.
package pea_pkg;

    localparam int DEF_WIDTH     = 16;  // x and coefficient width
    localparam int DEF_OUT_W     = 32;  // result/status word width
    localparam int DEF_N_MAX     = 10;  // highest supported degree
    localparam int DEF_COEF_SETS = 32;  // number of coefficient sets
    localparam int DEF_ADDR_W    = 9;   // clog2(COEF_SETS*(N_MAX+1))

    localparam int STATUS_OVF_BIT    = 0;
    localparam int STATUS_BADDEG_BIT = 1;
    localparam int STATUS_N_LSB      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ACC,
        ST_WRITE,
        ST_DONE
    } state_e;

    function automatic logic [DEF_OUT_W-1:0] make_status(input logic [7:0] deg,
                                                         input logic       bad_deg,
                                                         input logic       ovf);
        logic [DEF_OUT_W-1:0] s;
        s                       = '0;
        s[STATUS_N_LSB +: 8]    = deg;
        s[STATUS_BADDEG_BIT]    = bad_deg;
        s[STATUS_OVF_BIT]       = ovf;
        return s;
    endfunction

endpackage

// File: rtl/pea_horner_mac.sv
// One Horner step: sum = acc*x + c.
// The product is formed at OUT_W+WIDTH+1 bits so nothing is lost before
// truncation; ovf_o flags any set bit above the OUT_W-bit result.
// Ports:
//   acc_i  OUT_W  running accumulator
//   x_i    WIDTH  evaluation point
//   c_i    WIDTH  coefficient
//   sum_o  OUT_W  (acc*x + c) mod 2^OUT_W
//   ovf_o  1      intermediate exceeded OUT_W bits
module pea_horner_mac #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 32
) (
    input  logic [OUT_W-1:0] acc_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [OUT_W-1:0] sum_o,
    output logic             ovf_o
);
    localparam int FULL_W = OUT_W + WIDTH + 1;

    logic [FULL_W-1:0] full;

    assign full  = FULL_W'(acc_i) * FULL_W'(x_i) + FULL_W'(c_i);
    assign sum_o = full[OUT_W-1:0];
    assign ovf_o = |full[FULL_W-1:OUT_W];

endmodule

// File: rtl/pea_evp_engine.sv
// PEA EVP execution stage: evaluates p(x) = sum c_i*x^i (i = 0..n) by
// Horner's rule, fetching coefficients highest-degree first from the
// coefficient RAM, then writes one result and one status word to the
// output FIFOs and pulses fc_o.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i                1-cycle start, honoured only when idle
//   x_i, b_i, n_i          evaluation point, coefficient set, degree
//   coef_rd_en_o/addr_o    RAM read request (data returns next cycle)
//   coef_data_i            RAM read data
//   free_result_i/status_i free slots in the output FIFOs
//   wr_out_o               write strobe to both output FIFOs
//   result_o, status_o     words written by wr_out_o (held between writes)
//   busy_o, fc_o           not idle / completion pulse
module pea_evp_engine
    import pea_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int N_MAX     = DEF_N_MAX,
    parameter int COEF_SETS = DEF_COEF_SETS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [WIDTH-1:0]             x_i,
    input  logic [$clog2(COEF_SETS)-1:0] b_i,
    input  logic [7:0]                   n_i,
    output logic                         coef_rd_en_o,
    output logic [ADDR_W-1:0]            coef_addr_o,
    input  logic [WIDTH-1:0]             coef_data_i,
    input  logic [5:0]                   free_result_i,
    input  logic [5:0]                   free_status_i,
    output logic                         wr_out_o,
    output logic [OUT_W-1:0]             result_o,
    output logic [OUT_W-1:0]             status_o,
    output logic                         busy_o,
    output logic                         fc_o
);
    localparam int B_W = $clog2(COEF_SETS);

    state_e              state_q,  state_d;
    logic [WIDTH-1:0]    x_q,      x_d;
    logic [B_W-1:0]      b_q,      b_d;
    logic [7:0]          n_q,      n_d;
    logic [7:0]          idx_q,    idx_d;
    logic [OUT_W-1:0]    acc_q,    acc_d;
    logic                ovf_q,    ovf_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [OUT_W-1:0]    result_q, result_d;
    logic [OUT_W-1:0]    status_q, status_d;

    logic [OUT_W-1:0]    mac_sum;
    logic                mac_ovf;
    logic [OUT_W-1:0]    acc_step;
    logic                ovf_step;

    function automatic logic [ADDR_W-1:0] coef_addr_of(input logic [B_W-1:0] set,
                                                      input logic [7:0]     i);
        return ADDR_W'(set) * ADDR_W'(N_MAX + 1) + ADDR_W'(i);
    endfunction

    pea_horner_mac #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_mac (
        .acc_i (acc_q),
        .x_i   (x_q),
        .c_i   (coef_data_i),
        .sum_o (mac_sum),
        .ovf_o (mac_ovf)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        b_d          = b_q;
        n_d          = n_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        addr_d       = addr_q;
        result_d     = result_q;
        status_d     = status_q;
        acc_step     = mac_sum;
        ovf_step     = ovf_q | mac_ovf;
        coef_rd_en_o = 1'b0;
        wr_out_o     = 1'b0;
        fc_o         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    x_d   = x_i;
                    b_d   = b_i;
                    n_d   = n_i;
                    idx_d = n_i;
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (n_i > 8'(N_MAX)) begin
                        // Unsupported degree: report immediately, no RAM traffic.
                        result_d = '0;
                        status_d = OUT_W'(make_status(n_i, 1'b1, 1'b0));
                        state_d  = ST_WRITE;
                    end else begin
                        addr_d  = coef_addr_of(b_i, n_i);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                coef_rd_en_o = 1'b1;
                state_d      = ST_ACC;
            end
            ST_ACC: begin
                // The leading coefficient seeds the accumulator directly.
                if (idx_q == n_q) begin
                    acc_step = OUT_W'(coef_data_i);
                    ovf_step = ovf_q;
                end
                acc_d = acc_step;
                ovf_d = ovf_step;
                if (idx_q == 8'd0) begin
                    result_d = acc_step;
                    status_d = OUT_W'(make_status(n_q, 1'b0, ovf_step));
                    state_d  = ST_WRITE;
                end else begin
                    idx_d   = idx_q - 8'd1;
                    addr_d  = coef_addr_of(b_q, idx_q - 8'd1);
                    state_d = ST_FETCH;
                end
            end
            ST_WRITE: begin
                // Both FIFOs are written together, so both need room.
                if (free_result_i != 6'd0 && free_status_i != 6'd0) begin
                    wr_out_o = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                fc_o    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            addr_q   <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            b_q      <= b_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            addr_q   <= addr_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign coef_addr_o = addr_q;
    assign result_o    = result_q;
    assign status_o    = status_q;

endmodule

// File: tb/tb_pea_evp_engine.sv
// Self-checking bench for pea_evp_engine. Coefficient RAM is modelled with a
// registered read; expected results come from a direct polynomial evaluation.
module tb_pea_evp_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [4:0]  b = '0;
    logic [7:0]  n = '0;
    logic        coef_rd_en;
    logic [8:0]  coef_addr;
    logic [15:0] coef_data = '0;
    logic [5:0]  free_result = 6'd20;
    logic [5:0]  free_status = 6'd20;
    logic        wr_out;
    logic [31:0] result;
    logic [31:0] status;
    logic        busy;
    logic        fc;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:351];

    // Observations of the latest run, cycle k = k-th cycle after start.
    int          o_nrd, o_wr_cnt, o_wr_k, o_fc_cnt, o_fc_k;
    logic [31:0] o_res, o_stat;
    logic [8:0]  o_addrs [$];

    pea_evp_engine dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .x_i           (x),
        .b_i           (b),
        .n_i           (n),
        .coef_rd_en_o  (coef_rd_en),
        .coef_addr_o   (coef_addr),
        .coef_data_i   (coef_data),
        .free_result_i (free_result),
        .free_status_i (free_status),
        .wr_out_o      (wr_out),
        .result_o      (result),
        .status_o      (status),
        .busy_o        (busy),
        .fc_o          (fc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (coef_rd_en && coef_addr < 9'd352) coef_data <= mem[coef_addr];
    end

    // Direct evaluation of p(x) highest term first, exact 64-bit arithmetic.
    function automatic void ref_eval(input logic [4:0] rb, input logic [7:0] rn,
                                     input logic [15:0] rx,
                                     output logic [31:0] r, output logic [31:0] s);
        logic [63:0] acc;
        logic [63:0] full;
        logic        ovf;
        if (rn > 8'd10) begin
            r = 32'h0;
            s = {16'h0, rn, 6'b0, 1'b1, 1'b0};
            return;
        end
        acc = 64'h0;
        ovf = 1'b0;
        for (int i = int'(rn); i >= 0; i--) begin
            full = acc * 64'(rx) + 64'(mem[int'(rb) * 11 + i]);
            if (full[63:32] != 32'h0) ovf = 1'b1;
            acc = {32'h0, full[31:0]};
        end
        r = acc[31:0];
        s = {16'h0, rn, 6'b0, 1'b0, ovf};
    endfunction

    // Launches one evaluation and records what the DUT does; hold = cycles
    // of free_result==0 once the write becomes due.
    task automatic do_run(input logic [4:0] rb, input logic [7:0] rn,
                          input logic [15:0] rx, input int hold);
        int kw;
        int stop_k;
        kw = (rn > 8'd10) ? 1 : 2 * (int'(rn) + 1) + 1;
        o_nrd = 0; o_wr_cnt = 0; o_wr_k = -1; o_fc_cnt = 0; o_fc_k = -1;
        o_res = '0; o_stat = '0;
        o_addrs.delete();
        stop_k = -1;
        free_result = (hold > 0) ? 6'd0 : 6'd20;
        @(posedge clk); #1;
        start = 1'b1; x = rx; b = rb; n = rn;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                // Scramble inputs: the engine must have latched them.
                start = 1'b0;
                x = 16'($urandom); b = 5'($urandom); n = 8'($urandom);
            end
            if (hold > 0 && k == kw + hold) free_result = 6'd20;
            #1;
            if (coef_rd_en) begin
                o_nrd++;
                o_addrs.push_back(coef_addr);
            end
            if (wr_out) begin
                o_wr_cnt++;
                if (o_wr_k < 0) begin
                    o_wr_k = k; o_res = result; o_stat = status;
                end
            end
            if (fc) begin
                o_fc_cnt++;
                if (o_fc_k < 0) o_fc_k = k;
            end
            if (o_fc_k >= 0 && stop_k < 0) stop_k = k + 3;
            if (k == stop_k) break;
        end
        free_result = 6'd20;
        $display("run b=%0d n=%0d x=%h -> result=%h status=%h wr@%0d fc@%0d reads=%0d",
                 rb, rn, rx, o_res, o_stat, o_wr_k, o_fc_k, o_nrd);
    endtask

    task automatic test_reset();
        start = 1'b1; n = 8'd2;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (wr_out !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", wr_out); end
        total++; if (fc !== 1'b0) begin bad++; $display("FAIL reset_fc: got %b want 0", fc); end
        total++; if (coef_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", coef_rd_en); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        total++; if (status !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", status); end
        total++; if (coef_addr !== 9'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", coef_addr); end
        start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got %b want 0", busy); end
    endtask

    task automatic test_example();
        mem[33] = 16'd1; mem[34] = 16'd2; mem[35] = 16'd3;
        do_run(5'd3, 8'd2, 16'd2, 0);
        total++; if (o_res !== 32'd17) begin bad++; $display("FAIL ex_result: got %h want 00000011", o_res); end
        total++; if (o_stat !== 32'h0000_0200) begin bad++; $display("FAIL ex_status: got %h want 00000200", o_stat); end
        total++; if (o_wr_k !== 7) begin bad++; $display("FAIL ex_wr_cycle: got %0d want 7", o_wr_k); end
        total++; if (o_fc_k !== 8) begin bad++; $display("FAIL ex_fc_cycle: got %0d want 8", o_fc_k); end
        total++; if (o_wr_cnt !== 1 || o_fc_cnt !== 1) begin bad++; $display("FAIL ex_counts: got wr=%0d fc=%0d want 1/1", o_wr_cnt, o_fc_cnt); end
        total++;
        if (o_nrd !== 3 || o_addrs[0] !== 9'd35 || o_addrs[1] !== 9'd34 || o_addrs[2] !== 9'd33) begin
            bad++; $display("FAIL ex_addrs: got %0d reads want 35,34,33", o_nrd);
        end
    endtask

    task automatic test_degree0();
        mem[77] = 16'h1234;
        do_run(5'd7, 8'd0, 16'hFFFF, 0);
        total++; if (o_res !== 32'h1234) begin bad++; $display("FAIL d0_result: got %h want 00001234", o_res); end
        total++; if (o_stat !== 32'h0) begin bad++; $display("FAIL d0_status: got %h want 00000000", o_stat); end
        total++; if (o_wr_k !== 3) begin bad++; $display("FAIL d0_wr_cycle: got %0d want 3", o_wr_k); end
        total++; if (o_fc_k !== 4) begin bad++; $display("FAIL d0_fc_cycle: got %0d want 4", o_fc_k); end
        total++;
        if (o_nrd !== 1 || o_addrs[0] !== 9'd77) begin
            bad++; $display("FAIL d0_reads: got %0d reads want one at 77", o_nrd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] er, es;
        for (int i = 0; i < 4; i++) mem[99 + i] = 16'hFFFF;
        ref_eval(5'd9, 8'd3, 16'hFFFF, er, es);
        do_run(5'd9, 8'd3, 16'hFFFF, 0);
        total++; if (o_res !== er) begin bad++; $display("FAIL ovf_result: got %h want %h", o_res, er); end
        total++; if (o_stat[0] !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", o_stat[0]); end
        total++; if (o_stat !== es) begin bad++; $display("FAIL ovf_status: got %h want %h", o_stat, es); end
    endtask

    task automatic test_bad_degree();
        do_run(5'd2, 8'd11, 16'h0042, 0);
        total++; if (o_nrd !== 0) begin bad++; $display("FAIL bd_reads: got %0d want 0", o_nrd); end
        total++; if (o_res !== 32'h0) begin bad++; $display("FAIL bd_result: got %h want 0", o_res); end
        total++; if (o_stat !== 32'h0000_0B02) begin bad++; $display("FAIL bd_status: got %h want 00000b02", o_stat); end
        total++; if (o_wr_k !== 1) begin bad++; $display("FAIL bd_wr_cycle: got %0d want 1", o_wr_k); end
        total++; if (o_fc_k !== 2) begin bad++; $display("FAIL bd_fc_cycle: got %0d want 2", o_fc_k); end
    endtask

    task automatic test_backpressure();
        logic [31:0] er, es;
        logic [15:0] rx;
        rx = 16'($urandom);
        ref_eval(5'd20, 8'd2, rx, er, es);
        do_run(5'd20, 8'd2, rx, 5);
        total++; if (o_wr_k !== 12) begin bad++; $display("FAIL bp_wr_cycle: got %0d want 12", o_wr_k); end
        total++; if (o_wr_cnt !== 1) begin bad++; $display("FAIL bp_wr_count: got %0d want 1", o_wr_cnt); end
        total++; if (o_fc_k !== 13) begin bad++; $display("FAIL bp_fc_cycle: got %0d want 13", o_fc_k); end
        total++; if (o_res !== er) begin bad++; $display("FAIL bp_result: got %h want %h", o_res, er); end
    endtask

    task automatic test_random();
        logic [4:0]  rb;
        logic [7:0]  rn;
        logic [15:0] rx;
        logic [31:0] er, es;
        int          ew;
        for (int t = 0; t < 10; t++) begin
            rb = 5'($urandom_range(0, 31));
            rn = (t == 6) ? 8'($urandom_range(11, 255)) : 8'($urandom_range(0, 10));
            rx = 16'($urandom);
            ref_eval(rb, rn, rx, er, es);
            ew = (rn > 8'd10) ? 1 : 2 * (int'(rn) + 1) + 1;
            do_run(rb, rn, rx, 0);
            total++; if (o_res !== er) begin bad++; $display("FAIL rnd_result[%0d]: got %h want %h", t, o_res, er); end
            total++; if (o_stat !== es) begin bad++; $display("FAIL rnd_status[%0d]: got %h want %h", t, o_stat, es); end
            total++;
            if (o_wr_k !== ew || o_fc_k !== ew + 1) begin
                bad++; $display("FAIL rnd_timing[%0d]: got wr=%0d fc=%0d want wr=%0d fc=%0d", t, o_wr_k, o_fc_k, ew, ew + 1);
            end
            if (rn <= 8'd10) begin
                total++;
                if (o_nrd !== int'(rn) + 1) begin
                    bad++; $display("FAIL rnd_nreads[%0d]: got %0d want %0d", t, o_nrd, int'(rn) + 1);
                end else begin
                    for (int i = 0; i < o_nrd; i++) begin
                        total++;
                        if (o_addrs[i] !== 9'(int'(rb) * 11 + int'(rn) - i)) begin
                            bad++; $display("FAIL rnd_addr[%0d.%0d]: got %0d want %0d", t, i, o_addrs[i], int'(rb) * 11 + int'(rn) - i);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int          nw, nf;
        logic [15:0] rx;
        logic [31:0] er, es;
        rx = 16'($urandom);
        @(posedge clk); #1;
        start = 1'b1; b = 5'd12; n = 8'd5; x = rx;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 2) begin start = 1'b1; b = 5'd3; n = 8'd0; end
            if (k == 3) begin
                start = 1'b0;
                #1;
                total++;
                if (coef_rd_en !== 1'b1 || coef_addr !== 9'd136) begin
                    bad++; $display("FAIL abort_busy_start: got rd=%b addr=%0d want rd=1 addr=136", coef_rd_en, coef_addr);
                end
            end
            if (k == 4) rst_n = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || wr_out !== 1'b0 || fc !== 1'b0 || coef_rd_en !== 1'b0) begin
            bad++; $display("FAIL abort_ctrl: got busy=%b wr=%b fc=%b rd=%b want all 0", busy, wr_out, fc, coef_rd_en);
        end
        total++;
        if (result !== 32'h0 || status !== 32'h0 || coef_addr !== 9'h0) begin
            bad++; $display("FAIL abort_data: got result=%h status=%h addr=%h want 0", result, status, coef_addr);
        end
        nw = 0; nf = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (wr_out) nw++;
            if (fc) nf++;
        end
        total++; if (nw !== 0 || nf !== 0) begin bad++; $display("FAIL abort_quiet: got wr=%0d fc=%0d want 0/0", nw, nf); end
        ref_eval(5'd12, 8'd5, rx, er, es);
        do_run(5'd12, 8'd5, rx, 0);
        total++; if (o_res !== er) begin bad++; $display("FAIL abort_rerun_result: got %h want %h", o_res, er); end
        total++; if (o_stat !== es) begin bad++; $display("FAIL abort_rerun_status: got %h want %h", o_stat, es); end
        total++; if (o_wr_k !== 13) begin bad++; $display("FAIL abort_rerun_wr: got %0d want 13", o_wr_k); end
    endtask

    initial begin
        for (int i = 0; i < 352; i++) mem[i] = 16'($urandom);
        test_reset();
        test_example();
        test_degree0();
        test_overflow();
        test_bad_degree();
        test_backpressure();
        test_random();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
